pmem_line_responder: RTL and testbench

//  Responder end of the cache-to-physical-memory line interface (pmem_read/pmem_write/pmem_resp).

---
 rtl/pmem_line_responder.sv | 163 ++++++++++++++++
 tb/tb_pmem_line_responder.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_responder.sv
// pmem_line_responder
// Responder side of the cache <-> physical memory line interface. A full-line
// read or write request is turned into a fixed-length burst of BEAT_W-wide
// beats on the memory bus. pmem_resp pulses for one cycle when the burst ends.
module pmem_line_responder #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic [ADDR_W-1:0] burst_addr,
    output logic              burst_read,
    output logic              burst_write,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_ack
);

    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_BYTES = LINE_W / 8;

    // Clearing the in-line byte offset gives the line-aligned burst address.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]    beat_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic [BEAT_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                resp_q, resp_d;

    assign beat_nxt = beat_cnt_q + 1'b1;

    // Next-state, beat counting and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        addr_d     = addr_q;
        line_d     = line_q;
        rdata_d    = rdata_q;
        wdata_d    = wdata_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        resp_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Write has priority when both requests are raised together.
                if (pmem_write) begin
                    addr_d     = pmem_address & ALIGN_MASK;
                    line_d     = pmem_wdata;
                    wdata_d    = pmem_wdata[BEAT_W-1:0];
                    beat_cnt_d = '0;
                    wr_d       = 1'b1;
                    state_d    = WR_BURST;
                end else if (pmem_read) begin
                    addr_d     = pmem_address & ALIGN_MASK;
                    beat_cnt_d = '0;
                    rd_d       = 1'b1;
                    state_d    = RD_BURST;
                end
            end

            RD_BURST: begin
                rd_d = 1'b1;
                if (burst_ack) begin
                    line_d[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = burst_rdata;
                    if (beat_cnt_q == LAST_BEAT) begin
                        // Publish the assembled line only on completion so the
                        // previous read result stays visible during the burst.
                        rdata_d    = line_d;
                        beat_cnt_d = '0;
                        rd_d       = 1'b0;
                        resp_d     = 1'b1;
                        state_d    = RESP;
                    end else begin
                        beat_cnt_d = beat_nxt;
                    end
                end
            end

            WR_BURST: begin
                wr_d = 1'b1;
                if (burst_ack) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        wdata_d    = '0;
                        wr_d       = 1'b0;
                        resp_d     = 1'b1;
                        state_d    = RESP;
                    end else begin
                        beat_cnt_d = beat_nxt;
                        wdata_d    = line_q[int'(beat_nxt)*BEAT_W +: BEAT_W];
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered outputs; reset aborts any burst at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            resp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            resp_q     <= resp_d;
        end
    end

    // Line buffer: write data latched at accept, read beats assembled here.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign pmem_rdata  = rdata_q;
    assign pmem_resp   = resp_q;
    assign burst_addr  = addr_q;
    assign burst_read  = rd_q;
    assign burst_write = wr_q;
    assign burst_wdata = wdata_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder (default parameters).
module tb_pmem_line_responder;

    logic         clk;
    logic         reset_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  burst_addr;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_ack;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [255:0] rd_line1;
    logic [255:0] rd_line2;
    logic [255:0] rd_line3;
    logic [255:0] rd_line4;
    logic [255:0] wr_line1;
    logic [255:0] wr_line2;
    logic [255:0] wr_line3;

    pmem_line_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .burst_addr   (burst_addr),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_ack    (burst_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; inputs driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a read with ack tied high, feeding beats of 'line' in ascending order.
    // Returns the cycle (request cycle = 0) at which pmem_resp was seen, or -1.
    task automatic run_read(input logic [31:0] addr, input logic [255:0] line,
                            output int resp_cyc, output logic [255:0] got);
        int k;
        logic was_rd;
        k            = 0;
        resp_cyc     = -1;
        got          = '0;
        pmem_read    = 1'b1;
        pmem_address = addr;
        burst_ack    = 1'b1;
        burst_rdata  = line[63:0];
        tick();
        for (int cyc = 1; cyc < 20; cyc++) begin
            if (pmem_resp) begin
                resp_cyc = cyc;
                got      = pmem_rdata;
                break;
            end
            burst_rdata = line[k*64 +: 64];
            was_rd      = burst_read;
            tick();
            if (was_rd && k < 3) k++;
        end
        pmem_read = 1'b0;
        burst_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({pmem_resp, burst_read, burst_write} !== 3'b000) begin
            $display("FAIL reset_strobes: got %b expected 000", {pmem_resp, burst_read, burst_write});
        end else pass_cnt++;
        total_cnt++;
        if (pmem_rdata !== 256'h0) begin
            $display("FAIL reset_rdata: got %h expected 0", pmem_rdata);
        end else pass_cnt++;
        total_cnt++;
        if (burst_addr !== 32'h0 || burst_wdata !== 64'h0) begin
            $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", burst_addr, burst_wdata);
        end else pass_cnt++;
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if ({pmem_resp, burst_read, burst_write} !== 3'b000) begin
            $display("FAIL idle_after_reset: got %b expected 000", {pmem_resp, burst_read, burst_write});
        end else pass_cnt++;
    endtask

    task automatic test_read();
        logic bad_strobe;
        bad_strobe   = 1'b0;
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_1234;
        burst_ack    = 1'b1;
        burst_rdata  = 64'h0;
        tick();
        total_cnt++;
        if (burst_addr !== 32'h0000_1220) begin
            $display("FAIL read_burst_addr: got %h expected 00001220", burst_addr);
        end else pass_cnt++;
        // Cycles 1..4: one beat per cycle, no response yet.
        for (int k = 0; k < 4; k++) begin
            burst_rdata = rd_line1[k*64 +: 64];
            if (burst_read !== 1'b1 || burst_write !== 1'b0 || pmem_resp !== 1'b0 ||
                burst_addr !== 32'h0000_1220)
                bad_strobe = 1'b1;
            tick();
        end
        total_cnt++;
        if (bad_strobe !== 1'b0) begin
            $display("FAIL read_beats_strobes: got bad=%b expected 0", bad_strobe);
        end else pass_cnt++;
        total_cnt++;
        if (pmem_resp !== 1'b1) begin
            $display("FAIL read_resp_cycle5: got %b expected 1", pmem_resp);
        end else pass_cnt++;
        total_cnt++;
        if (burst_read !== 1'b0) begin
            $display("FAIL read_strobe_in_resp: got %b expected 0", burst_read);
        end else pass_cnt++;
        total_cnt++;
        if (pmem_rdata !== rd_line1) begin
            $display("FAIL read_rdata: got %h expected %h", pmem_rdata, rd_line1);
        end else pass_cnt++;
        pmem_read = 1'b0;
        burst_ack = 1'b0;
        tick();
        total_cnt++;
        if (pmem_resp !== 1'b0) begin
            $display("FAIL read_resp_one_cycle: got %b expected 0", pmem_resp);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        int rc;
        logic [255:0] got;
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_3000;
        burst_ack    = 1'b1;
        tick();
        burst_rdata = 64'h5555_0000_0000_0000;
        tick();
        burst_rdata = 64'h5555_0000_0000_0001;
        tick();
        // Two beats accepted; beat 2 is current. Reset between edges.
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({pmem_resp, burst_read, burst_write} !== 3'b000) begin
            $display("FAIL midreset_strobes: got %b expected 000", {pmem_resp, burst_read, burst_write});
        end else pass_cnt++;
        total_cnt++;
        if (burst_addr !== 32'h0 || pmem_rdata !== 256'h0 || burst_wdata !== 64'h0) begin
            $display("FAIL midreset_data: got addr=%h rdata=%h expected 0", burst_addr, pmem_rdata);
        end else pass_cnt++;
        pmem_read = 1'b0;
        burst_ack = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (pmem_resp !== 1'b0 || burst_read !== 1'b0) begin
            $display("FAIL midreset_no_resp: got resp=%b rd=%b expected 0/0", pmem_resp, burst_read);
        end else pass_cnt++;
        run_read(32'h0000_3010, rd_line3, rc, got);
        total_cnt++;
        if (rc !== 5) begin
            $display("FAIL after_reset_latency: got %0d expected 5", rc);
        end else pass_cnt++;
        total_cnt++;
        if (got !== rd_line3) begin
            $display("FAIL after_reset_rdata: got %h expected %h", got, rd_line3);
        end else pass_cnt++;
    endtask

    task automatic test_write_slow_ack();
        logic [255:0] prev_rdata;
        int resp_cnt;
        prev_rdata   = rd_line3;
        resp_cnt     = 0;
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_8008;
        pmem_wdata   = wr_line1;
        burst_ack    = 1'b0;
        tick();
        total_cnt++;
        if (burst_write !== 1'b1 || burst_read !== 1'b0 || burst_addr !== 32'h0000_8000) begin
            $display("FAIL write_start: got wr=%b rd=%b addr=%h expected 1/0/00008000",
                     burst_write, burst_read, burst_addr);
        end else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            burst_ack = 1'b0;
            total_cnt++;
            if (burst_wdata !== wr_line1[k*64 +: 64] || burst_write !== 1'b1) begin
                $display("FAIL write_beat%0d_stall: got %h expected %h", k, burst_wdata, wr_line1[k*64 +: 64]);
            end else pass_cnt++;
            resp_cnt += int'(pmem_resp);
            tick();
            burst_ack = 1'b1;
            total_cnt++;
            if (burst_wdata !== wr_line1[k*64 +: 64]) begin
                $display("FAIL write_beat%0d_held: got %h expected %h", k, burst_wdata, wr_line1[k*64 +: 64]);
            end else pass_cnt++;
            resp_cnt += int'(pmem_resp);
            tick();
        end
        burst_ack = 1'b0;
        total_cnt++;
        if (pmem_resp !== 1'b1 || burst_write !== 1'b0) begin
            $display("FAIL write_resp: got resp=%b wr=%b expected 1/0", pmem_resp, burst_write);
        end else pass_cnt++;
        resp_cnt += int'(pmem_resp);
        total_cnt++;
        if (pmem_rdata !== prev_rdata) begin
            $display("FAIL write_keeps_rdata: got %h expected %h", pmem_rdata, prev_rdata);
        end else pass_cnt++;
        pmem_write = 1'b0;
        tick();
        resp_cnt += int'(pmem_resp);
        tick();
        resp_cnt += int'(pmem_resp);
        total_cnt++;
        if (resp_cnt !== 1) begin
            $display("FAIL write_single_resp: got %0d expected 1", resp_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int resp_cnt;
        logic overlap;
        resp_cnt     = 0;
        overlap      = 1'b0;
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0100;
        pmem_wdata   = wr_line2;
        burst_ack    = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            overlap  |= burst_read & burst_write;
            resp_cnt += int'(pmem_resp);
            tick();
        end
        total_cnt++;
        if (pmem_resp !== 1'b1) begin
            $display("FAIL b2b_write_resp: got %b expected 1", pmem_resp);
        end else pass_cnt++;
        resp_cnt  += int'(pmem_resp);
        pmem_write = 1'b0;
        tick();
        // First IDLE cycle after RESP: raise the read here.
        overlap  |= burst_read & burst_write;
        resp_cnt += int'(pmem_resp);
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_0040;
        tick();
        total_cnt++;
        if (burst_read !== 1'b1 || burst_addr !== 32'h0000_0040) begin
            $display("FAIL b2b_read_accepted: got rd=%b addr=%h expected 1/00000040", burst_read, burst_addr);
        end else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            burst_rdata = rd_line2[k*64 +: 64];
            overlap    |= burst_read & burst_write;
            resp_cnt   += int'(pmem_resp);
            tick();
        end
        total_cnt++;
        if (pmem_resp !== 1'b1 || pmem_rdata !== rd_line2) begin
            $display("FAIL b2b_read_resp: got resp=%b rdata=%h expected 1/%h", pmem_resp, pmem_rdata, rd_line2);
        end else pass_cnt++;
        resp_cnt += int'(pmem_resp);
        pmem_read = 1'b0;
        burst_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            overlap  |= burst_read & burst_write;
            resp_cnt += int'(pmem_resp);
        end
        total_cnt++;
        if (resp_cnt !== 2) begin
            $display("FAIL b2b_resp_count: got %0d expected 2", resp_cnt);
        end else pass_cnt++;
        total_cnt++;
        if (overlap !== 1'b0) begin
            $display("FAIL b2b_strobe_overlap: got %b expected 0", overlap);
        end else pass_cnt++;
    endtask

    task automatic test_both_requests();
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0200;
        pmem_wdata   = wr_line3;
        burst_ack    = 1'b1;
        tick();
        total_cnt++;
        if (burst_write !== 1'b1 || burst_read !== 1'b0 || burst_wdata !== wr_line3[63:0]) begin
            $display("FAIL both_write_wins: got wr=%b rd=%b wdata=%h expected 1/0/%h",
                     burst_write, burst_read, burst_wdata, wr_line3[63:0]);
        end else pass_cnt++;
        for (int k = 0; k < 4; k++) tick();
        total_cnt++;
        if (pmem_resp !== 1'b1 || pmem_rdata !== rd_line2) begin
            $display("FAIL both_rdata_unchanged: got resp=%b rdata=%h expected 1/%h", pmem_resp, pmem_rdata, rd_line2);
        end else pass_cnt++;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        burst_ack  = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_stall();
        logic held_bad;
        held_bad     = 1'b0;
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_2004;
        burst_ack    = 1'b1;
        tick();
        burst_rdata = rd_line4[63:0];
        tick();
        burst_rdata = rd_line4[127:64];
        tick();
        // Two beats taken; now withhold ack for 20 cycles with junk on the bus.
        burst_ack   = 1'b0;
        burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int k = 0; k < 20; k++) begin
            if (burst_read !== 1'b1 || burst_addr !== 32'h0000_2000 || pmem_resp !== 1'b0)
                held_bad = 1'b1;
            tick();
        end
        total_cnt++;
        if (held_bad !== 1'b0) begin
            $display("FAIL stall_hold: got bad=%b expected 0", held_bad);
        end else pass_cnt++;
        burst_ack   = 1'b1;
        burst_rdata = rd_line4[191:128];
        tick();
        burst_rdata = rd_line4[255:192];
        tick();
        total_cnt++;
        if (pmem_resp !== 1'b1 || pmem_rdata !== rd_line4) begin
            $display("FAIL stall_resume: got resp=%b rdata=%h expected 1/%h", pmem_resp, pmem_rdata, rd_line4);
        end else pass_cnt++;
        pmem_read = 1'b0;
        burst_ack = 1'b0;
        tick();
    endtask

    initial begin
        reset_n      = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'h0;
        pmem_wdata   = '0;
        burst_rdata  = 64'h0;
        burst_ack    = 1'b0;
        rd_line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        rd_line2 = {64'h0D0D_0D0D_0000_0004, 64'h0C0C_0C0C_0000_0003,
                    64'h0B0B_0B0B_0000_0002, 64'h0A0A_0A0A_0000_0001};
        rd_line3 = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                    64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
        rd_line4 = {64'hF0F0_F0F0_F0F0_0004, 64'hE0E0_E0E0_E0E0_0003,
                    64'hD0D0_D0D0_D0D0_0002, 64'hC0C0_C0C0_C0C0_0001};
        wr_line1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        wr_line2 = {64'h0123_4567_89AB_CDEF, 64'h1032_5476_98BA_DCFE,
                    64'h2301_6745_AB89_EFCD, 64'h3210_7654_BA98_FEDC};
        wr_line3 = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                    64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
        #1;
        test_reset();
        test_read();
        test_reset_mid_burst();
        test_write_slow_ack();
        test_back_to_back();
        test_both_requests();
        test_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
